// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: command bytes,
// FSM state encoding and the default register address width.
package uart_cmd_pkg;

    localparam int DEFAULT_ADDR_W = 4;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_REQ,
        TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Byte-level command decoder behind the UART: turns write/read frames into
// single-cycle register strobes and sends read data back as one byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_p_data,
    input  logic              rx_data_valid,
    input  logic              rx_par_err,
    input  logic              rx_frame_err,
    output logic [7:0]        tx_p_data,
    output logic              tx_data_valid,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wr_data,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rd_data,
    input  logic              reg_rd_valid,
    output logic              cmd_err
);

    state_t            state_q;
    logic              seenBusy_q;
    logic [7:0]        txData_q;
    logic              txValid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wrData_q;
    logic              wrEn_q;
    logic              rdEn_q;
    logic              cmdErr_q;

    logic byteErr;
    logic byteOk;
    logic addrLegal;

    assign byteErr   = rx_data_valid & (rx_par_err | rx_frame_err);
    assign byteOk    = rx_data_valid & ~rx_par_err & ~rx_frame_err;
    assign addrLegal = (rx_p_data[7:ADDR_W] == '0);

    // A corrupted byte aborts whatever is in flight, including a pending reply.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            seenBusy_q <= 1'b0;
            txData_q   <= '0;
            txValid_q  <= 1'b0;
            addr_q     <= '0;
            wrData_q   <= '0;
            wrEn_q     <= 1'b0;
            rdEn_q     <= 1'b0;
            cmdErr_q   <= 1'b0;
        end else begin
            txValid_q <= 1'b0;
            wrEn_q    <= 1'b0;
            rdEn_q    <= 1'b0;
            cmdErr_q  <= 1'b0;
            if (byteErr) begin
                state_q    <= IDLE;
                seenBusy_q <= 1'b0;
                cmdErr_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (byteOk) begin
                            if (rx_p_data == CMD_WR) begin
                                state_q <= WR_ADDR;
                            end else if (rx_p_data == CMD_RD) begin
                                state_q <= RD_ADDR;
                            end else begin
                                cmdErr_q <= 1'b1;
                            end
                        end
                    end
                    WR_ADDR: begin
                        if (byteOk) begin
                            if (addrLegal) begin
                                addr_q  <= rx_p_data[ADDR_W-1:0];
                                state_q <= WR_DATA;
                            end else begin
                                cmdErr_q <= 1'b1;
                                state_q  <= IDLE;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (byteOk) begin
                            wrData_q <= rx_p_data;
                            wrEn_q   <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                    RD_ADDR: begin
                        if (byteOk) begin
                            if (addrLegal) begin
                                addr_q  <= rx_p_data[ADDR_W-1:0];
                                rdEn_q  <= 1'b1;
                                state_q <= RD_WAIT;
                            end else begin
                                cmdErr_q <= 1'b1;
                                state_q  <= IDLE;
                            end
                        end
                    end
                    // Bytes arriving while a reply is outstanding are overruns.
                    RD_WAIT: begin
                        if (byteOk) cmdErr_q <= 1'b1;
                        if (reg_rd_valid) begin
                            txData_q <= reg_rd_data;
                            state_q  <= TX_REQ;
                        end
                    end
                    TX_REQ: begin
                        if (byteOk) cmdErr_q <= 1'b1;
                        if (!tx_busy) begin
                            txValid_q  <= 1'b1;
                            seenBusy_q <= 1'b0;
                            state_q    <= TX_WAIT;
                        end
                    end
                    TX_WAIT: begin
                        if (byteOk) cmdErr_q <= 1'b1;
                        if (tx_busy) begin
                            seenBusy_q <= 1'b1;
                        end else if (seenBusy_q) begin
                            seenBusy_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_p_data     = txData_q;
    assign tx_data_valid = txValid_q;
    assign reg_addr      = addr_q;
    assign reg_wr_data   = wrData_q;
    assign reg_wr_en     = wrEn_q;
    assign reg_rd_en     = rdEn_q;
    assign cmd_err       = cmdErr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized frame-level bench for uart_cmd_ctrl: a register-file responder,
// a transmitter busy model and a frame-level expectation model.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int AW = DEFAULT_ADDR_W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    rx_p_data = '0;
    logic          rx_data_valid = 1'b0;
    logic          rx_par_err = 1'b0;
    logic          rx_frame_err = 1'b0;
    logic [7:0]    tx_p_data;
    logic          tx_data_valid;
    logic          tx_busy = 1'b0;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wr_data;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [7:0]    reg_rd_data = '0;
    logic          reg_rd_valid = 1'b0;
    logic          cmd_err;

    uart_cmd_ctrl #(.ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST),
        .rx_p_data(rx_p_data), .rx_data_valid(rx_data_valid),
        .rx_par_err(rx_par_err), .rx_frame_err(rx_frame_err),
        .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .cmd_err(cmd_err)
    );

    always #5 CLK = ~CLK;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] mem [2**AW];
    int rdDelay = 0;
    int busyLen = 3;
    logic busyHold = 1'b0;
    int txBusyCnt = 0;

    // Expected frame-level effects
    int expWr = 0, expRd = 0, expTx = 0, expErr = 0;
    logic [AW-1:0] expAddr = '0, expLastWrAddr = '0, expLastRdAddr = '0;
    logic [7:0] expWrReg = '0, expTxReg = '0, expLastWrData = '0, expLastTx = '0;

    // Observed strobes
    int obsWr = 0, obsRd = 0, obsTx = 0, obsErr = 0;
    logic [AW-1:0] obsWrAddr = '0, obsRdAddr = '0;
    logic [7:0] obsWrData = '0, obsTx8 = '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        if (reg_wr_en) begin obsWr++; obsWrAddr = reg_addr; obsWrData = reg_wr_data; end
        if (reg_rd_en) begin obsRd++; obsRdAddr = reg_addr; end
        if (tx_data_valid) begin obsTx++; obsTx8 = tx_p_data; end
        if (cmd_err) obsErr++;
    end

    // Transmitter stays busy for busyLen cycles after each request
    initial forever begin
        @(negedge CLK); #1;
        if (tx_data_valid) txBusyCnt = busyLen;
        else if (txBusyCnt > 0) txBusyCnt--;
        tx_busy = (txBusyCnt > 0) || busyHold;
    end

    // Register file answers each read after rdDelay cycles
    initial forever begin
        @(negedge CLK); #1;
        if (reg_rd_en) begin
            repeat (rdDelay) begin @(negedge CLK); #1; end
            reg_rd_data  = mem[reg_addr];
            reg_rd_valid = 1'b1;
            @(negedge CLK); #1;
            reg_rd_valid = 1'b0;
            reg_rd_data  = 8'($urandom);
        end
    end

    task automatic sendByte(input logic [7:0] b, input logic pe, input logic fe, input int gap);
        rx_p_data     = b;
        rx_data_valid = 1'b1;
        rx_par_err    = pe;
        rx_frame_err  = fe;
        @(negedge CLK);
        rx_data_valid = 1'b0;
        rx_par_err    = 1'b0;
        rx_frame_err  = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    function automatic int randGap();
        return int'($urandom_range(0, 2));
    endfunction

    // kind: 0 write, 1 read, 2 bad command, 3 bad address, 4 aborted write,
    // 5 aborted read, 6 read with an overrun byte
    task automatic applyStimulus(input int kind, input logic [7:0] a, input logic [7:0] d, input int errPos);
        logic [7:0] frame [3];
        logic [7:0] c;
        logic pe;
        case (kind)
            0: begin
                sendByte(CMD_WR, 1'b0, 1'b0, randGap());
                sendByte(a, 1'b0, 1'b0, randGap());
                sendByte(d, 1'b0, 1'b0, 0);
                checkOutput("wrStrobe", 32'(reg_wr_en), 1);
                checkOutput("wrAddrAtStrobe", 32'(reg_addr), 32'(a));
                expWr++; expAddr = a[AW-1:0]; expWrReg = d;
                expLastWrAddr = a[AW-1:0]; expLastWrData = d;
            end
            1, 6: begin
                sendByte(CMD_RD, 1'b0, 1'b0, randGap());
                sendByte(a, 1'b0, 1'b0, 0);
                checkOutput("rdStrobe", 32'(reg_rd_en), 1);
                if (kind == 6) begin
                    sendByte(8'($urandom), 1'b0, 1'b0, 0);
                    checkOutput("overrunErr", 32'(cmd_err), 1);
                    expErr++;
                end
                expRd++; expAddr = a[AW-1:0]; expLastRdAddr = a[AW-1:0];
                expTx++; expTxReg = mem[a[AW-1:0]]; expLastTx = mem[a[AW-1:0]];
            end
            2: begin
                c = (d == CMD_WR || d == CMD_RD) ? 8'h42 : d;
                sendByte(c, 1'b0, 1'b0, 0);
                checkOutput("badCmdErr", 32'(cmd_err), 1);
                expErr++;
            end
            3: begin
                sendByte((errPos == 0) ? CMD_WR : CMD_RD, 1'b0, 1'b0, randGap());
                sendByte(a, 1'b0, 1'b0, 0);
                checkOutput("badAddrErr", 32'(cmd_err), 1);
                checkOutput("badAddrNoRd", 32'(reg_rd_en), 0);
                expErr++;
            end
            4, 5: begin
                frame[0] = (kind == 4) ? CMD_WR : CMD_RD;
                frame[1] = a;
                frame[2] = d;
                for (int i = 0; i < errPos; i++) sendByte(frame[i], 1'b0, 1'b0, randGap());
                pe = 1'($urandom_range(0, 1));
                sendByte(8'($urandom), pe, ~pe | 1'($urandom_range(0, 1)), 0);
                checkOutput("abortErr", 32'(cmd_err), 1);
                checkOutput("abortNoWr", 32'(reg_wr_en), 0);
                checkOutput("abortNoRd", 32'(reg_rd_en), 0);
                if (kind == 4 && errPos == 2) expAddr = a[AW-1:0];
                expErr++;
            end
            default: ;
        endcase
        repeat (2) @(negedge CLK);
    endtask

    // Wait for any outstanding reply and for the transmitter to go idle
    task automatic settle();
        int n = 0;
        while (obsTx < expTx && n < 300) begin
            @(negedge CLK); #2;
            n++;
        end
        repeat (busyLen + 4) @(negedge CLK);
        #2;
    endtask

    task automatic checkFrame();
        checkOutput("wrCount", obsWr, expWr);
        checkOutput("rdCount", obsRd, expRd);
        checkOutput("txCount", obsTx, expTx);
        checkOutput("errCount", obsErr, expErr);
        checkOutput("regAddrHold", 32'(reg_addr), 32'(expAddr));
        checkOutput("wrDataHold", 32'(reg_wr_data), 32'(expWrReg));
        checkOutput("txDataHold", 32'(tx_p_data), 32'(expTxReg));
        if (expWr > 0) begin
            checkOutput("lastWrAddr", 32'(obsWrAddr), 32'(expLastWrAddr));
            checkOutput("lastWrData", 32'(obsWrData), 32'(expLastWrData));
        end
        if (expRd > 0) checkOutput("lastRdAddr", 32'(obsRdAddr), 32'(expLastRdAddr));
        if (expTx > 0) checkOutput("lastTxByte", 32'(obsTx8), 32'(expLastTx));
    endtask

    initial begin
        logic [7:0] savedLastTx;
        int kind;
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom);
        mem[7] = 8'hA5;

        repeat (3) @(negedge CLK);
        checkOutput("resetOutputs", 32'({tx_p_data, tx_data_valid, reg_addr, reg_wr_data,
                                         reg_wr_en, reg_rd_en, cmd_err}), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        applyStimulus(0, 8'h03, 8'h5C, 0);
        settle(); checkFrame();

        rdDelay = 2; busyLen = 10;
        applyStimulus(1, 8'h07, 8'h00, 0);
        settle(); checkFrame();

        busyHold = 1'b1; rdDelay = 1; busyLen = 4;
        applyStimulus(1, 8'h09, 8'h00, 0);
        repeat (20) @(negedge CLK);
        checkOutput("noTxWhileBusy", 32'(tx_data_valid), 0);
        checkOutput("txCountWhileBusy", obsTx, expTx - 1);
        busyHold = 1'b0;
        @(negedge CLK);
        checkOutput("txAfterBusyFall", 32'(tx_data_valid), 1);
        checkOutput("txDataAfterBusyFall", 32'(tx_p_data), 32'(mem[9]));
        settle(); checkFrame();

        applyStimulus(4, 8'h03, 8'h11, 2);
        settle(); checkFrame();
        applyStimulus(2, 8'h00, 8'h42, 0);
        settle(); checkFrame();
        applyStimulus(3, 8'h1F, 8'h00, 1);
        settle(); checkFrame();
        rdDelay = 3;
        applyStimulus(6, 8'h05, 8'h00, 0);
        settle(); checkFrame();

        for (int n = 0; n < 40; n++) begin
            rdDelay = int'($urandom_range(0, 3));
            busyLen = int'($urandom_range(1, 10));
            kind = int'($urandom_range(0, 6));
            case (kind)
                3:       applyStimulus(3, 8'($urandom_range(16, 255)), 8'h00, int'($urandom_range(0, 1)));
                4:       applyStimulus(4, 8'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(0, 2)));
                5:       applyStimulus(5, 8'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(0, 1)));
                default: applyStimulus(kind, 8'($urandom_range(0, 15)), 8'($urandom), 0);
            endcase
            settle(); checkFrame();
        end

        // The reply pending in TX_REQ is lost when reset hits
        busyHold = 1'b1; rdDelay = 0;
        savedLastTx = expLastTx;
        applyStimulus(1, 8'h0C, 8'h00, 0);
        repeat (5) @(negedge CLK);
        #1 RST = 1'b1;
        #1 checkOutput("resetMidFrame", 32'({tx_p_data, tx_data_valid, reg_addr, reg_wr_data,
                                             reg_wr_en, reg_rd_en, cmd_err}), 0);
        expTx--; expLastTx = savedLastTx;
        expTxReg = '0; expAddr = '0; expWrReg = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        busyHold = 1'b0;
        repeat (30) @(negedge CLK);
        #2 checkFrame();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
